// File: rtl/player_collision_detector.sv
// Player/obstacle overlap detector with per-frame evaluation, life tracking,
// post-hit invulnerability window and defeat reporting.
module player_collision_detector #(
  parameter int unsigned PLAYER_SIZE   = 16,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_DIV     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_on,
  input  logic        play_selected,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [27:0] delayed_signals,
  input  logic [35:0] obstacle_data,
  output logic [2:0]  lives,
  output logic        hit,
  output logic        invulnerable,
  output logic        blink,
  output logic        defeat
);

  localparam int unsigned BLINK_W    = $clog2(BLINK_DIV);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  TIMER_INIT = 8'(INVULN_FRAMES);
  localparam logic [12:0] BOX_SPAN   = 13'(PLAYER_SIZE - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_INVULN  = 2'd2,
    ST_DEFEAT  = 2'd3
  } state_t;

  logic [11:0] vcount_s;
  logic [11:0] hcount_s;
  logic        vsync_s;
  logic        blank_s;
  logic        obstacle_pixel_s;
  logic        in_box_s;
  logic        boundary_s;
  logic [12:0] x_lo_s;
  logic [12:0] x_hi_s;
  logic [12:0] y_lo_s;
  logic [12:0] y_hi_s;
  logic        unused_bits_s;

  logic        cand_r;
  logic        vsync_r;
  logic        vsync_prev_r;
  logic        frame_hit_r;
  state_t      state_r;
  logic [2:0]  lives_r;
  logic [7:0]  timer_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic        hit_r;
  logic        invulnerable_r;
  logic        blink_r;
  logic        defeat_r;

  assign vcount_s      = delayed_signals[27:16];
  assign vsync_s       = delayed_signals[15];
  assign hcount_s      = delayed_signals[13:2];
  assign blank_s       = delayed_signals[14] | delayed_signals[0];
  assign unused_bits_s = ^{delayed_signals[1], obstacle_data[11:0]};

  // Box bounds carry a 13th bit so a player near the right/bottom edge never wraps to 0.
  assign x_lo_s = {1'b0, xpos};
  assign x_hi_s = {1'b0, xpos} + BOX_SPAN;
  assign y_lo_s = {1'b0, ypos};
  assign y_hi_s = {1'b0, ypos} + BOX_SPAN;

  assign obstacle_pixel_s = (obstacle_data[35:24] == hcount_s) &&
                            (obstacle_data[23:12] == vcount_s) && !blank_s;
  assign in_box_s = ({1'b0, hcount_s} >= x_lo_s) && ({1'b0, hcount_s} <= x_hi_s) &&
                    ({1'b0, vcount_s} >= y_lo_s) && ({1'b0, vcount_s} <= y_hi_s);
  assign boundary_s = vsync_r & ~vsync_prev_r;

  // Candidate register and vsync edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_r       <= 1'b0;
      vsync_r      <= 1'b0;
      vsync_prev_r <= 1'b0;
    end else begin
      cand_r       <= obstacle_pixel_s & in_box_s & game_on;
      vsync_r      <= vsync_s;
      vsync_prev_r <= vsync_r;
    end
  end

  // Game FSM: sticky frame hit, lives, invulnerability timer and blink.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      frame_hit_r    <= 1'b0;
      lives_r        <= LIVES_INIT;
      timer_r        <= 8'd0;
      blink_cnt_r    <= '0;
      hit_r          <= 1'b0;
      invulnerable_r <= 1'b0;
      blink_r        <= 1'b1;
      defeat_r       <= 1'b0;
    end else begin
      hit_r <= 1'b0;
      if (play_selected) begin
        state_r        <= ST_PLAYING;
        frame_hit_r    <= 1'b0;
        lives_r        <= LIVES_INIT;
        timer_r        <= 8'd0;
        blink_cnt_r    <= '0;
        invulnerable_r <= 1'b0;
        blink_r        <= 1'b1;
        defeat_r       <= 1'b0;
      end else if (boundary_s) begin
        // A candidate landing on the boundary cycle belongs to the new frame.
        frame_hit_r <= cand_r;
        case (state_r)
          ST_PLAYING: begin
            if (frame_hit_r && game_on) begin
              hit_r <= 1'b1;
              if (lives_r <= 3'd1) begin
                state_r        <= ST_DEFEAT;
                lives_r        <= 3'd0;
                defeat_r       <= 1'b1;
                invulnerable_r <= 1'b0;
                blink_r        <= 1'b1;
              end else begin
                state_r        <= ST_INVULN;
                lives_r        <= lives_r - 3'd1;
                timer_r        <= TIMER_INIT;
                blink_cnt_r    <= '0;
                invulnerable_r <= 1'b1;
                blink_r        <= 1'b0;
              end
            end
          end
          ST_INVULN: begin
            if (game_on) begin
              if (timer_r <= 8'd1) begin
                state_r        <= ST_PLAYING;
                timer_r        <= 8'd0;
                blink_cnt_r    <= '0;
                invulnerable_r <= 1'b0;
                blink_r        <= 1'b1;
              end else begin
                timer_r     <= timer_r - 8'd1;
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
                if (blink_cnt_r == BLINK_LAST) begin
                  blink_r <= ~blink_r;
                end
              end
            end
          end
          default: begin
          end
        endcase
      end else begin
        frame_hit_r <= frame_hit_r | cand_r;
      end
    end
  end

  assign lives        = lives_r;
  assign hit          = hit_r;
  assign invulnerable = invulnerable_r;
  assign blink        = blink_r;
  assign defeat       = defeat_r;

endmodule

// File: doc/player_collision_detector.md
Name: player_collision_detector

Overview:
- Consumer end of the obstacle pipeline: takes the muxed `obstacle_data` bus and the one-cycle-delayed timing bus, and detects overlap between the active obstacle's pixels and the player square at (xpos, ypos).
- Evaluates once per frame.
- Manages the player's lives with an invulnerability window after each hit.
- Reports `defeat` to the game-state logic; this is the counterpart of the obstacle side's `victory`/`done` reporting.

Parameters:
- PLAYER_SIZE, 16, side length in pixels of the player hit box.
- LIVES, 3, lives loaded on start; 1..7.
- INVULN_FRAMES, 60, frames of hit immunity after a hit; 1..255.
- BLINK_DIV, 8, frames per half-period of the `blink` output during invulnerability; power of 2, ≥2.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- game_on  in  1  gameplay active; low = pause
- play_selected  in  1  start/restart request, level
- xpos  in  12  player left edge
- ypos  in  12  player top edge
- delayed_signals  in  28  fields: [27:16] vcount, [15] vsync, [14] vblnk, [13:2] hcount, [1] hsync, [0] hblnk
- obstacle_data  in  36  fields: [35:24] obstacle_x, [23:12] obstacle_y, [11:0] rgb
- lives  out  3  remaining lives
- hit  out  1  one-cycle pulse when a life is lost
- invulnerable  out  1  immunity window active
- blink  out  1  player-visibility toggle; 1 outside invulnerability
- defeat  out  1  level, lives exhausted

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, lives=LIVES, hit=0, invulnerable=0, blink=1, defeat=0.
  - Internal frame_hit, timers and vsync history cleared.
- Obstacle pixel definition:
  - A pixel belongs to the obstacle when obstacle_x==hcount and obstacle_y==vcount.
  - Obstacle modules drive their own coordinates only on obstacle pixels.
  - rgb is ignored.
  - Pixels are ignored when vblnk or hblnk is set.
- In-box test:
  - Condition: xpos ≤ hcount ≤ xpos+PLAYER_SIZE-1 and ypos ≤ vcount ≤ ypos+PLAYER_SIZE-1.
  - Bounds are computed in 13 bits, so xpos near 4095 does not wrap to 0.
- Pipeline:
  - Stage 1 registers the candidate = obstacle pixel AND in-box AND game_on.
  - Stage 2 sets a sticky frame_hit.
  - Pixel-to-frame_hit latency is 2 cycles.
- Frame boundary:
  - Defined as the cycle where registered vsync is 1 and its previous value was 0 (rising edge).
  - At the boundary, frame_hit is evaluated and then cleared.
  - A stage-2 set arriving on the same cycle is counted in the next frame.
- State machine:
  - IDLE:
    - play_selected=1 → PLAYING, lives=LIVES.
  - PLAYING:
    - At a boundary with frame_hit=1 and game_on=1: lives-=1 and hit=1 for exactly one cycle, the cycle after the boundary.
    - If the new lives==0 → DEFEAT.
    - Otherwise → INVULN, with the frame timer loaded to INVULN_FRAMES.
  - INVULN:
    - invulnerable=1; frame_hit is discarded at each boundary.
    - The timer decrements per boundary only while game_on=1; pause freezes it.
    - At timer==0 → PLAYING at that boundary.
    - blink toggles every BLINK_DIV boundaries, starting at 0 on entry.
  - DEFEAT:
    - defeat=1, invulnerable=0, blink=1.
    - Hits ignored; lives stays 0.
    - play_selected=1 → PLAYING with lives=LIVES, defeat=0.
- Global rules:
  - play_selected=1 in PLAYING or INVULN reloads lives=LIVES, clears the timer and frame_hit, and enters PLAYING.
  - play_selected has priority over a simultaneous boundary.
  - game_on=0: no candidates are generated and state is held; an already-set frame_hit is still discarded at the next boundary without penalty.
  - Reset asserted mid-frame or mid-invulnerability returns everything to reset values immediately; there are no pending pulses after release.
- Arithmetic:
  - lives never underflows below 0.
  - The timer is 8 bits, saturating at 0.

Test Plan:
- Reset, play_selected=1, xpos=ypos=100, obstacle pixel injected at hcount=vcount=108 with blank low, then vsync rise → single-cycle hit one cycle after the edge, lives 3→2, invulnerable=1.
- Same pixel at hcount=116 (outside 100..115) → no hit across 3 frames, lives=3.
- INVULN_FRAMES=4, a hit every frame → lives decrements only on frames 1 and 6.
- Three spaced hits → lives=0, defeat=1, further hits ignored; play_selected → lives=3, defeat=0.
- game_on=0 during INVULN for 10 frames → timer frozen, invulnerable stays 1; a hit candidate during pause → no decrement.
- xpos=4090, PLAYER_SIZE=16, obstacle pixel at hcount=2 → no hit (no wrap); rst pulsed low mid-INVULN → lives=3, invulnerable=0, blink=1 asynchronously.
